// File: rtl/div_pkg.sv
// Shared types for the pipelined restoring divider: stage payload and widths.
// Optional DIVIDER_ZERO_FLAG_EN adds a divide-by-zero flag to the payload.
package div_pkg;

  localparam int DIV_DATA_WIDTH     = 16;
  localparam int DIV_PIPELINE_DEPTH = 4;
  localparam int DIV_REM_WIDTH      = DIV_DATA_WIDTH + 1;

  typedef struct packed {
    logic [DIV_REM_WIDTH-1:0]  rem;
    logic [DIV_DATA_WIDTH-1:0] dividend;
    logic [DIV_DATA_WIDTH-1:0] divisor;
    logic [DIV_DATA_WIDTH-1:0] quotient;
    logic                      valid;
`ifdef DIVIDER_ZERO_FLAG_EN
    logic                      zero;
`endif
  } div_payload_t;

  // A set MSB on the result means the subtraction borrowed.
  function automatic logic [DIV_REM_WIDTH-1:0] div_trial(
    input logic [DIV_REM_WIDTH-1:0]  rem,
    input logic [DIV_DATA_WIDTH-1:0] divisor
  );
    return rem - {1'b0, divisor};
  endfunction

endpackage

// File: rtl/pipelined_array_divider_stage.sv
// Combinational restoring-division slice resolving STEPS quotient bits MSB-first.
module pipelined_array_divider_stage
  import div_pkg::*;
#(
  parameter int STEPS = 4
) (
  input  div_payload_t payload_i,
  output div_payload_t payload_o
);

  div_payload_t               work_s;
  logic [DIV_REM_WIDTH-1:0]   shifted_s;
  logic [DIV_REM_WIDTH-1:0]   trial_s;

  // Unrolled shift/subtract/restore steps.
  always_comb begin
    work_s    = payload_i;
    shifted_s = '0;
    trial_s   = '0;
    for (int i = 0; i < STEPS; i++) begin
      shifted_s       = {work_s.rem[DIV_DATA_WIDTH-1:0], work_s.dividend[DIV_DATA_WIDTH-1]};
      trial_s         = div_trial(shifted_s, work_s.divisor);
      work_s.dividend = {work_s.dividend[DIV_DATA_WIDTH-2:0], 1'b0};
      if (trial_s[DIV_DATA_WIDTH] == 1'b0) begin
        work_s.rem      = trial_s;
        work_s.quotient = {work_s.quotient[DIV_DATA_WIDTH-2:0], 1'b1};
      end else begin
        work_s.rem      = shifted_s;
        work_s.quotient = {work_s.quotient[DIV_DATA_WIDTH-2:0], 1'b0};
      end
    end
    payload_o = work_s;
  end

endmodule

// File: rtl/pipelined_array_divider.sv
// Fully pipelined unsigned restoring divider; owns all stage registers.
// Build option DIVIDER_ZERO_FLAG_EN adds divide_by_zero_o. DATA_WIDTH must match div_pkg.
module pipelined_array_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH     = DIV_DATA_WIDTH,
  parameter int PIPELINE_DEPTH = DIV_PIPELINE_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  data_valid_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  data_valid_o
`ifdef DIVIDER_ZERO_FLAG_EN
  ,
  output logic                  divide_by_zero_o
`endif
);

  localparam int QUOTIENT_PER_STAGE = DATA_WIDTH / PIPELINE_DEPTH;

  div_payload_t entry_s;
  div_payload_t stage_in_s  [PIPELINE_DEPTH];
  div_payload_t stage_out_s [PIPELINE_DEPTH];
  div_payload_t stage_r     [PIPELINE_DEPTH];
  logic         unused_last_s;

  // Stage 0 starts from a zero partial remainder and the raw operands.
  always_comb begin
    entry_s          = '0;
    entry_s.dividend = dividend_i;
    entry_s.divisor  = divisor_i;
    entry_s.valid    = data_valid_i;
`ifdef DIVIDER_ZERO_FLAG_EN
    entry_s.zero     = (divisor_i == {DATA_WIDTH{1'b0}});
`endif
  end

  for (genvar g = 0; g < PIPELINE_DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign stage_in_s[g] = entry_s;
    end else begin : g_rest
      assign stage_in_s[g] = stage_r[g-1];
    end

    pipelined_array_divider_stage #(
      .STEPS(QUOTIENT_PER_STAGE)
    ) u_stage (
      .payload_i(stage_in_s[g]),
      .payload_o(stage_out_s[g])
    );
  end

  // Stage registers; data loads regardless of valid, everything holds when stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < PIPELINE_DEPTH; k++) begin
        stage_r[k] <= '0;
      end
    end else if (clk_en_i) begin
      for (int k = 0; k < PIPELINE_DEPTH; k++) begin
        stage_r[k] <= stage_out_s[k];
      end
    end
  end

  assign quotient_o   = stage_r[PIPELINE_DEPTH-1].quotient;
  assign remainder_o  = stage_r[PIPELINE_DEPTH-1].rem[DATA_WIDTH-1:0];
  assign data_valid_o = stage_r[PIPELINE_DEPTH-1].valid;
`ifdef DIVIDER_ZERO_FLAG_EN
  assign divide_by_zero_o = stage_r[PIPELINE_DEPTH-1].zero;
`endif

  // Exhausted dividend, divisor and the remainder guard bit are dead at the last stage.
  assign unused_last_s = ^{stage_r[PIPELINE_DEPTH-1].rem[DATA_WIDTH],
                           stage_r[PIPELINE_DEPTH-1].dividend,
                           stage_r[PIPELINE_DEPTH-1].divisor};

endmodule

// File: tb/tb_pipelined_array_divider.sv
// Self-checking bench for pipelined_array_divider against an arithmetic reference model.
module tb_pipelined_array_divider;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          clk_en_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic          data_valid_i;
  logic [DW-1:0] quotient_o;
  logic [DW-1:0] remainder_o;
  logic          data_valid_o;
`ifdef DIVIDER_ZERO_FLAG_EN
  logic          divide_by_zero_o;
`endif

  typedef struct {
    int unsigned q;
    int unsigned r;
    logic        z;
    int unsigned due;
  } exp_t;

  exp_t          exp_fifo[$];
  int unsigned   en_cnt;
  int unsigned   chk_cnt;
  int unsigned   pass_cnt;
  logic          exp_valid;
  logic [DW-1:0] exp_quo;
  logic [DW-1:0] exp_rem;
  logic          exp_z;

  always #5 clk_i = ~clk_i;

  pipelined_array_divider #(
    .DATA_WIDTH(DW),
    .PIPELINE_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .clk_en_i(clk_en_i),
    .dividend_i(dividend_i),
    .divisor_i(divisor_i),
    .data_valid_i(data_valid_i),
    .quotient_o(quotient_o),
    .remainder_o(remainder_o),
    .data_valid_o(data_valid_o)
`ifdef DIVIDER_ZERO_FLAG_EN
    ,
    .divide_by_zero_o(divide_by_zero_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_outputs();
    check("valid", {31'd0, data_valid_o}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("quotient", {16'd0, quotient_o}, {16'd0, exp_quo});
      check("remainder", {16'd0, remainder_o}, {16'd0, exp_rem});
`ifdef DIVIDER_ZERO_FLAG_EN
      check("zero_flag", {31'd0, divide_by_zero_o}, {31'd0, exp_z});
`endif
    end
  endtask

  // One clock: drive inputs, advance the model on enabled edges, compare.
  task automatic step(input logic en, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    clk_en_i     = en;
    data_valid_i = v;
    dividend_i   = a;
    divisor_i    = b;
    @(posedge clk_i);
    #1;
    if (en) begin
      en_cnt++;
      if (v) begin
        e.q   = (b == 16'd0) ? 32'hFFFF : 32'(a / b);
        e.r   = (b == 16'd0) ? 32'(a) : 32'(a % b);
        e.z   = (b == 16'd0);
        e.due = en_cnt + DEPTH - 1;
        exp_fifo.push_back(e);
      end
      if (exp_fifo.size() > 0 && exp_fifo[0].due == en_cnt) begin
        e         = exp_fifo.pop_front();
        exp_valid = 1'b1;
        exp_quo   = e.q[DW-1:0];
        exp_rem   = e.r[DW-1:0];
        exp_z     = e.z;
      end else begin
        exp_valid = 1'b0;
      end
    end
    check_outputs();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {31'd0, data_valid_o}, 32'd0);
    check({tag, "_q"}, {16'd0, quotient_o}, 32'd0);
    check({tag, "_r"}, {16'd0, remainder_o}, 32'd0);
`ifdef DIVIDER_ZERO_FLAG_EN
    check({tag, "_z"}, {31'd0, divide_by_zero_o}, 32'd0);
`endif
  endtask

  initial begin
    logic          en;
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int unsigned   sel;

    rst_n_i      = 1'b0;
    clk_en_i     = 1'b0;
    data_valid_i = 1'b0;
    dividend_i   = '0;
    divisor_i    = '0;
    en_cnt       = 0;
    chk_cnt      = 0;
    pass_cnt     = 0;
    exp_valid    = 1'b0;
    exp_quo      = '0;
    exp_rem      = '0;
    exp_z        = 1'b0;

    #12;
    check_cleared("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1'b1, 1'b0, 16'd0, 16'd0);
    step(1'b1, 1'b0, 16'd0, 16'd0);

    // Single op: result exactly DEPTH enabled clocks later, for one cycle.
    step(1'b1, 1'b1, 16'd100, 16'd7);
    repeat (DEPTH - 1) step(1'b1, 1'b0, 16'd0, 16'd0);
    check("t100_valid", {31'd0, data_valid_o}, 32'd1);
    check("t100_q", {16'd0, quotient_o}, 32'd14);
    check("t100_r", {16'd0, remainder_o}, 32'd2);
    step(1'b1, 1'b0, 16'd0, 16'd0);

    // Boundary operands back to back.
    step(1'b1, 1'b1, 16'hFFFF, 16'h0001);
    step(1'b1, 1'b1, 16'd5, 16'd9);
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    step(1'b1, 1'b1, 16'd1234, 16'd0);
    step(1'b1, 1'b1, 16'd0, 16'd77);
    repeat (DEPTH + 2) step(1'b1, 1'b0, 16'd0, 16'd0);

    // Back-to-back ops with a two-cycle stall after the second issue.
    step(1'b1, 1'b1, 16'd50, 16'd3);
    step(1'b1, 1'b1, 16'd81, 16'd9);
    step(1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b1, 1'b1, 16'd7, 16'd2);
    step(1'b1, 1'b1, 16'd60000, 16'd255);
    step(1'b1, 1'b0, 16'd0, 16'd0);
    step(1'b1, 1'b0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 16'd0, 16'd0);
    repeat (DEPTH) step(1'b1, 1'b0, 16'd0, 16'd0);

    // Asynchronous reset with operations in flight.
    step(1'b1, 1'b1, 16'd900, 16'd30);
    step(1'b1, 1'b1, 16'd901, 16'd31);
    step(1'b1, 1'b1, 16'd902, 16'd0);
    #3;
    rst_n_i = 1'b0;
    #1;
    check_cleared("async_rst");
    exp_fifo.delete();
    exp_valid = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (8) step(1'b1, 1'b0, 16'd0, 16'd0);

    // Random regression with random stalls and idle slots.
    for (int i = 0; i < 10000; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      v   = ($urandom_range(0, 3) != 0);
      a   = DW'($urandom);
      sel = $urandom_range(0, 15);
      case (sel)
        0:       b = 16'd0;
        1:       b = 16'd1;
        2, 3:    b = DW'($urandom_range(1, 255));
        4:       b = a;
        default: b = DW'($urandom);
      endcase
      step(en, v, a, b);
    end
    repeat (DEPTH + 2) step(1'b1, 1'b0, 16'd0, 16'd0);
    check("drain_empty", exp_fifo.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipelined_array_divider.md
Name: pipelined_array_divider

Overview:
- Unsigned N-bit integer divider using the long binary (restoring) division algorithm.
- Companion to the pipelined array multiplier; shares the same parameterisation style and valid-propagation scheme.
- Quotient bits are resolved MSB-first, QUOTIENT_PER_STAGE bits per pipeline stage.
- Fully pipelined: one new operation may be accepted every enabled clock. Sits in the integer execution unit as the DIV/REM backend.

Parameters:
- DATA_WIDTH, 16, operand/result width in bits; must be a power of 2.
- PIPELINE_DEPTH, 4, number of registered stages; range 1..DATA_WIDTH; DATA_WIDTH must be divisible by PIPELINE_DEPTH.
- QUOTIENT_PER_STAGE (localparam), DATA_WIDTH/PIPELINE_DEPTH, quotient bits resolved per stage.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- clk_en_i  in  1  global stall; when 0 every register holds
- dividend_i  in  DATA_WIDTH  dividend
- divisor_i  in  DATA_WIDTH  divisor
- data_valid_i  in  1  operands valid this cycle
- quotient_o  out  DATA_WIDTH  quotient
- remainder_o  out  DATA_WIDTH  remainder
- data_valid_o  out  1  quotient/remainder valid

Behaviour:
- Reset: rst_n_i low clears all stage registers asynchronously; quotient_o=0, remainder_o=0, data_valid_o=0. In-flight operations are discarded; no stale valid after release.
- Per-stage state: partial remainder (DATA_WIDTH+1 bits), remaining dividend bits, divisor, quotient accumulated so far, valid bit. Every field is registered at each stage output.
- Stage step, repeated QUOTIENT_PER_STAGE times combinationally:
  - Shift the next dividend MSB into the partial remainder.
  - Compute trial = rem - {1'b0,divisor} at DATA_WIDTH+1 bits.
  - If trial has no borrow (MSB=0): rem=trial, q bit=1. Otherwise rem unchanged, q bit=0.
- Stage 0 consumes dividend_i/divisor_i directly with partial remainder 0. The last stage output registers drive quotient_o/remainder_o (remainder = low DATA_WIDTH bits).
- Latency: exactly PIPELINE_DEPTH enabled clocks from the data_valid_i sample to data_valid_o. Throughput is 1 op per enabled clock; results emerge in issue order.
- Valid propagation: data_valid_i rides the pipeline in lockstep with its data. Data registers load regardless of valid, but outputs are meaningful only when data_valid_o=1.
- clk_en_i=0: all registers, including valid, hold. Outputs remain stable, and data_valid_o stays at its held value.
- Divide by zero needs no special case. The algorithm yields quotient = all ones and remainder = dividend, which matches RISC-V semantics.
- Boundaries:
  - dividend < divisor gives q=0, r=dividend.
  - divisor=1 gives q=dividend, r=0.
  - dividend=0 gives q=0, r=0.
  - Maximum operands must not overflow, which is guaranteed by the (DATA_WIDTH+1)-bit remainder.
- No backpressure: the consumer must accept data_valid_o when it is asserted.

Optional Feature:
- Macro DIVIDER_ZERO_FLAG_EN.
- Defined: adds output divide_by_zero_o (1 bit).
  - Computed in stage 0 as (divisor_i==0) and pipelined alongside valid.
  - Asserted with data_valid_o for that operation; reset value 0; holds under clk_en_i=0.
- Undefined: port and logic are absent.
- Quotient/remainder results are identical in both configurations.

Decomposition:
- Shared package (div_pkg) holds:
  - The stage payload struct typedef: partial remainder, dividend shift register, divisor, quotient, valid, optional zero flag.
  - Width localparams.
- Sub-module pipelined_array_divider_stage: purely combinational QUOTIENT_PER_STAGE-step restoring slice.
  - Inputs: payload. Outputs: next payload.
  - Instantiated PIPELINE_DEPTH times via generate.
- The top level owns all registers, clock enable and reset.

Test Plan (DATA_WIDTH=16, PIPELINE_DEPTH=4):
- 100/7 with valid for 1 cycle -> after 4 clocks: data_valid_o=1, q=14, r=2 for exactly 1 cycle.
- 0xFFFF/0x0001 -> q=0xFFFF, r=0; 5/9 -> q=0, r=5; 0xFFFF/0xFFFF -> q=1, r=0.
- 1234/0 -> q=0xFFFF, r=1234; with DIVIDER_ZERO_FLAG_EN, divide_by_zero_o=1 coincident with valid, and 0 on other results.
- Four back-to-back ops (50/3, 81/9, 7/2, 60000/255), clk_en_i low 2 cycles after the 2nd issue:
  - Results arrive in order: (16,2), (9,0), (3,1), (235,75).
  - Final result appears 2 cycles later than without the stall; outputs stable during the stall.
- Issue 3 ops, then assert rst_n_i asynchronously between clock edges -> data_valid_o=0 and outputs 0 immediately. After release, no valid appears for 8 cycles without new input.
- Random regression: 10k random pairs, including divisor 0 -> match a reference model (q=a/b, r=a%b; b=0 gives all ones and a).
